// File: rtl/local_port_arbiter_pkg.sv
// Shared definitions for the local port arbiter: flit width and the
// Req/Gnt handshake state encodings used by injector-style blocks.
package local_port_arbiter_pkg;

    localparam int DataWidthDef = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_GNT = 2'b01,
        RELEASE  = 2'b10,
        HOLDOFF  = 2'b11
    } arbState_e;

    // Position of the requester 'offset' slots after 'base' on the ring.
    function automatic int wrapIndex(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

endpackage

// File: rtl/local_port_arbiter_rr_select.sv
// Round-robin requester selection: first set request after ptr, wrapping.
module rr_select
    import local_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               any,
    output logic [IDW-1:0]     winner
);

    logic [IDW-1:0] idx;

    // Walk the ring from farthest to nearest so the nearest hit is kept last.
    always_comb begin
        any    = 1'b0;
        winner = {IDW{1'b0}};
        idx    = {IDW{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx    = IDW'(wrapIndex(int'(ptr), k, NUM_REQ));
            winner = req[idx] ? idx : winner;
            any    = any | req[idx];
        end
    end

endmodule

// File: rtl/local_port_arbiter.sv
// Shares one router Local input port between NUM_REQ injectors with
// round-robin, one-packet-per-grant arbitration and a forwarded-packet counter.
module local_port_arbiter
    import local_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDW       = 2,
    parameter int dataWidth = DataWidthDef
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             ReqUpStr,
    input  logic [NUM_REQ*dataWidth-1:0]   PacketIn,
    output logic [NUM_REQ-1:0]             GntUpStr,
    output logic [NUM_REQ-1:0]             UpStrFull,
    output logic                           ReqDnStr,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [dataWidth-1:0]           PacketOut,
    output logic [31:0]                    PktCount
);

    arbState_e              state, stateNext;
    logic [IDW-1:0]         winner, winnerNext;
    logic [IDW-1:0]         ptr, ptrNext;
    logic                   reqDn, reqDnNext;
    logic [NUM_REQ-1:0]     gntUp, gntUpNext;
    logic [dataWidth-1:0]   packetOut, packetNext;
    logic [31:0]            pktCount;
    logic                   countEn;
    logic                   anyReq;
    logic [IDW-1:0]         selWinner;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) uSelect (
        .req    (ReqUpStr),
        .ptr    (ptr),
        .any    (anyReq),
        .winner (selWinner)
    );

    assign UpStrFull = {NUM_REQ{DnStrFull}};
    assign ReqDnStr  = reqDn;
    assign GntUpStr  = gntUp;
    assign PacketOut = packetOut;
    assign PktCount  = pktCount;

    // Next-state and next-register values for the handshake FSM.
    always_comb begin
        stateNext  = state;
        winnerNext = winner;
        ptrNext    = ptr;
        reqDnNext  = reqDn;
        gntUpNext  = {NUM_REQ{1'b0}};
        packetNext = packetOut;
        countEn    = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq && !DnStrFull) begin
                    winnerNext = selWinner;
                    packetNext = PacketIn[int'(selWinner)*dataWidth +: dataWidth];
                    reqDnNext  = 1'b1;
                    stateNext  = WAIT_GNT;
                end else begin
                    stateNext  = IDLE;
                end
            end
            WAIT_GNT: begin
                // A late DnStrFull does not retract; the router settles it via GntDnStr.
                if (GntDnStr) begin
                    reqDnNext = 1'b0;
                    gntUpNext = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    ptrNext   = winner;
                    countEn   = 1'b1;
                    stateNext = RELEASE;
                end else begin
                    stateNext = WAIT_GNT;
                end
            end
            RELEASE: begin
                stateNext = HOLDOFF;
            end
            HOLDOFF: begin
                // Wait for the winner to drop its request so it is not re-served.
                if (!ReqUpStr[winner]) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = HOLDOFF;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            winner    <= {IDW{1'b0}};
            ptr       <= IDW'(NUM_REQ - 1);
            reqDn     <= 1'b0;
            gntUp     <= {NUM_REQ{1'b0}};
            packetOut <= {dataWidth{1'b0}};
        end else begin
            state     <= stateNext;
            winner    <= winnerNext;
            ptr       <= ptrNext;
            reqDn     <= reqDnNext;
            gntUp     <= gntUpNext;
            packetOut <= packetNext;
        end
    end

    // Forwarded-packet counter, wraps modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pktCount <= 32'd0;
        end else if (countEn) begin
            pktCount <= pktCount + 32'd1;
        end
    end

endmodule

// File: tb/tb_local_port_arbiter.sv
// Self-checking bench for local_port_arbiter: vector table plus directed
// multi-cycle sequences, with an expected-grant scoreboard queue.
module tb_local_port_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     ReqUpStr;
    logic [NR*DW-1:0]  PacketIn;
    logic [NR-1:0]     GntUpStr;
    logic [NR-1:0]     UpStrFull;
    logic              ReqDnStr;
    logic              GntDnStr;
    logic              DnStrFull;
    logic [DW-1:0]     PacketOut;
    logic [31:0]       PktCount;

    local_port_arbiter #(.NUM_REQ(NR), .IDW(2), .dataWidth(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .PacketIn  (PacketIn),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .ReqDnStr  (ReqDnStr),
        .GntDnStr  (GntDnStr),
        .DnStrFull (DnStrFull),
        .PacketOut (PacketOut),
        .PktCount  (PktCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        int          expWin;
        int          gntDelay;
        logic [31:0] pkt;
    } vec_t;

    typedef struct {
        int          win;
        logic [31:0] pkt;
    } exp_t;

    vec_t        vecs [8];
    exp_t        expQ [$];
    int          nCompared;
    int          nMismatched;
    logic [31:0] expCount;
    int          tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int t, input int port);
        return {16'hC0DE, 8'(t), 8'(port)};
    endfunction

    task automatic checkGrant();
        exp_t       e;
        logic [3:0] expG;
        if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL grant at %0t: got %0h expected no grant", $time, GntUpStr);
        end else begin
            e    = expQ.pop_front();
            expG = 4'b0001 << e.win;
            check("grant", GntUpStr, expG);
            check("packet", PacketOut, e.pkt);
            expCount = expCount + 32'd1;
            check("count", PktCount, expCount);
        end
    endtask

    // One complete transaction: request, optional router wait, grant, release.
    task automatic runTxn(input logic [3:0] req, input int expWin, input int gntDelay,
                          input logic [31:0] winPkt);
        int waited;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            PacketIn[i*DW +: DW] = (i == expWin) ? winPkt : pat(tag, i);
        end
        ReqUpStr = req;
        expQ.push_back('{expWin, winPkt});
        tag++;
        waited = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            waited = n + 1;
            if (ReqDnStr) break;
        end
        check("req latency", waited, 1);
        for (int i = 0; i < NR; i++) begin
            if (i != expWin) PacketIn[i*DW +: DW] = 32'hDEADBEEF;
        end
        for (int d = 0; d < gntDelay; d++) begin
            @(negedge clk);
            check("req held", ReqDnStr, 1'b1);
        end
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        checkGrant();
        check("req dropped", ReqDnStr, 1'b0);
        ReqUpStr = 4'b0000;
        @(negedge clk);
        check("gnt pulse", GntUpStr, 4'b0000);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] drop [NR];
        int         got;
        int         lastCyc;
        int         waited;

        nCompared   = 0;
        nMismatched = 0;
        expCount    = 32'd0;
        tag         = 1;
        reset       = 1'b0;
        ReqUpStr    = 4'b0000;
        PacketIn    = '0;
        GntDnStr    = 1'b0;
        DnStrFull   = 1'b0;

        vecs[0] = '{4'b1111, 2, 0, 32'h1111_0001};
        vecs[1] = '{4'b1111, 3, 1, 32'h2222_0002};
        vecs[2] = '{4'b0101, 0, 2, 32'h3333_0003};
        vecs[3] = '{4'b0101, 2, 0, 32'h4444_0004};
        vecs[4] = '{4'b1010, 3, 3, 32'h5555_0005};
        vecs[5] = '{4'b1010, 1, 0, 32'h6666_0006};
        vecs[6] = '{4'b0001, 0, 1, 32'h7777_0007};
        vecs[7] = '{4'b1000, 3, 0, 32'h8888_0008};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ReqDnStr", ReqDnStr, 1'b0);
        check("rst GntUpStr", GntUpStr, 4'b0000);
        check("rst PacketOut", PacketOut, 32'h0);
        check("rst PktCount", PktCount, 32'h0);
        check("rst UpStrFull", UpStrFull, 4'b0000);
        reset = 1'b1;

        // Single requester, router grants two cycles after ReqDnStr
        runTxn(4'b0100, 2, 2, 32'h9C001005);

        // Downstream full blocks the request; late full does not retract
        @(negedge clk);
        DnStrFull = 1'b1;
        ReqUpStr  = 4'b0010;
        PacketIn[1*DW +: DW] = 32'hF00D_0001;
        expQ.push_back('{1, 32'hF00D_0001});
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("full no req", ReqDnStr, 1'b0);
            check("full UpStrFull", UpStrFull, 4'b1111);
        end
        DnStrFull = 1'b0;
        #1;
        check("UpStrFull latency", UpStrFull, 4'b0000);
        @(negedge clk);
        check("full release req", ReqDnStr, 1'b1);
        DnStrFull = 1'b1;
        #1;
        check("UpStrFull rise", UpStrFull, 4'b1111);
        @(negedge clk);
        check("no retract", ReqDnStr, 1'b1);
        DnStrFull = 1'b0;
        GntDnStr  = 1'b1;
        @(negedge clk);
        GntDnStr  = 1'b0;
        checkGrant();
        ReqUpStr  = 4'b0000;
        repeat (2) @(negedge clk);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            runTxn(vecs[v].req, vecs[v].expWin, vecs[v].gntDelay, vecs[v].pkt);
        end

        // All ports requesting continuously against a zero-wait router
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            PacketIn[i*DW +: DW] = pat(tag, i);
            drop[i] = 4'd0;
        end
        for (int k = 0; k < 8; k++) expQ.push_back('{k % NR, pat(tag, k % NR)});
        tag++;
        ReqUpStr = 4'b1111;
        got      = 0;
        lastCyc  = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            GntDnStr = ReqDnStr;
            if (GntUpStr != 4'b0000) begin
                if (got > 0) check("rr spacing", cyc - lastCyc, 4);
                lastCyc = cyc;
                got++;
                checkGrant();
                for (int i = 0; i < NR; i++) begin
                    if (GntUpStr[i]) drop[i] = 4'd2;
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (drop[i] != 4'd0) begin
                    ReqUpStr[i] = 1'b0;
                    drop[i]     = drop[i] - 4'd1;
                end else begin
                    ReqUpStr[i] = 1'b1;
                end
            end
        end
        check("rr grants", got, 8);
        ReqUpStr = 4'b0000;
        GntDnStr = 1'b0;
        expQ.delete();
        repeat (3) @(negedge clk);

        // Winner holds its request after the grant: no re-grant, port 3 next
        @(negedge clk);
        ReqUpStr = 4'b1001;
        PacketIn[0*DW +: DW] = 32'hAAAA_0000;
        PacketIn[3*DW +: DW] = 32'hBBBB_0003;
        expQ.push_back('{0, 32'hAAAA_0000});
        @(negedge clk);
        check("hold req", ReqDnStr, 1'b1);
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        checkGrant();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("holdoff no gnt", GntUpStr, 4'b0000);
            check("holdoff no req", ReqDnStr, 1'b0);
        end
        ReqUpStr = 4'b1000;
        expQ.push_back('{3, 32'hBBBB_0003});
        waited = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            waited = n + 1;
            if (ReqDnStr) break;
        end
        check("holdoff exit", waited, 2);
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        checkGrant();
        ReqUpStr = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset pulsed while waiting for the router grant
        @(negedge clk);
        ReqUpStr = 4'b0010;
        @(negedge clk);
        check("pre-reset req", ReqDnStr, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid rst ReqDnStr", ReqDnStr, 1'b0);
        check("mid rst GntUpStr", GntUpStr, 4'b0000);
        check("mid rst PacketOut", PacketOut, 32'h0);
        check("mid rst PktCount", PktCount, 32'h0);
        check("mid rst ptr", dut.ptr, 2'd3);
        ReqUpStr = 4'b0000;
        expCount = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        runTxn(4'b0011, 0, 0, 32'h0123_4567);

        // Counter wrap
        @(negedge clk);
        force dut.pktCount = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pktCount;
        @(negedge clk);
        check("preload", PktCount, 32'hFFFF_FFFF);
        expCount = 32'hFFFF_FFFF;
        runTxn(4'b0100, 2, 1, 32'h5A5A_A5A5);
        check("wrap", PktCount, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
